// File: rtl/glove_pkg.sv
// glove_pkg: shared types and constants for the frame sender slice.
//   FRAME_LEN  samples per frame
//   SAMPLE_W   sample width (two's complement)
//   HOP        samples between consecutive frames once the window is full
// Config macro FRAME_SENDER_OVERLAP_EN: defined -> HOP=20 (frames overlap by
// 20 samples); undefined -> HOP=40 (disjoint frames).
package glove_pkg;
  localparam int FRAME_LEN = 40;
  localparam int SAMPLE_W  = 16;
  localparam int CNT_W     = 6;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t [0:FRAME_LEN-1]    frame_t;

`ifdef FRAME_SENDER_OVERLAP_EN
  localparam int HOP = 20;
`else
  localparam int HOP = 40;
`endif

  typedef enum logic {ST_FILL, ST_STREAM} state_t;
endpackage

// File: rtl/sample_window.sv
// sample_window: 40-entry sample shift register with fill/hop counters.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   enable           low clears both counters and ignores samples
//   sample_valid     sample accepted when high together with enable
//   sample           incoming sample, shifts in at [FRAME_LEN-1]
//   streaming        window already full (control FSM in STREAM)
//   next_frame       window contents including the current sample
//   complete         this edge's accepted sample completes a frame
module sample_window
  import glove_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    enable,
  input  logic    sample_valid,
  input  sample_t sample,
  input  logic    streaming,
  output frame_t  next_frame,
  output logic    complete
);
  frame_t           window;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] hop;
  logic             accept;

  assign accept = enable & sample_valid;

  always_comb begin
    next_frame = window;
    for (int i = 0; i < FRAME_LEN-1; i++) next_frame[i] = window[i+1];
    next_frame[FRAME_LEN-1] = sample;
  end

  // First frame completes when fill reaches FRAME_LEN; afterwards every HOP.
  assign complete = accept &&
    (streaming ? (hop == CNT_W'(HOP-1)) : (fill == CNT_W'(FRAME_LEN-1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      window <= '0;
      fill   <= '0;
      hop    <= '0;
    end else if (!enable) begin
      fill <= '0;
      hop  <= '0;
    end else if (accept) begin
      window <= next_frame;
      if (fill != CNT_W'(FRAME_LEN)) fill <= fill + 1'b1;
      // hop only runs once the window is full; the completing edge leaves it at 0
      if (streaming) hop <= (hop == CNT_W'(HOP-1)) ? '0 : hop + 1'b1;
      else           hop <= '0;
    end
  end
endmodule

// File: rtl/frame_sender.sv
// frame_sender: collects sensor samples into 40-sample frames and hands each
// completed frame to a downstream recogniser with a one-cycle o_next pulse.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_enable         capture enable; low drops the partial window
//   i_sample_valid   sample strobe
//   i_sample         16-bit signed sample
//   i_core_ready     downstream idle
//   o_next           one-cycle frame-start pulse, o_data valid while high
//   o_data           delivered frame, [0] oldest .. [39] newest
//   o_pending        completed frame waiting for i_core_ready
//   o_drop_count     frames overwritten before delivery, saturating at 255
// Config macro FRAME_SENDER_OVERLAP_EN selects overlapping frames (see glove_pkg).
module frame_sender
  import glove_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_sample_valid,
  input  sample_t    i_sample,
  input  logic       i_core_ready,
  output logic       o_next,
  output frame_t     o_data,
  output logic       o_pending,
  output logic [7:0] o_drop_count
);
  state_t state_q, state_d;
  frame_t next_frame, hold;
  logic   complete, send;

  sample_window u_win (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .enable       (i_enable),
    .sample_valid (i_sample_valid),
    .sample       (i_sample),
    .streaming    (state_q == ST_STREAM),
    .next_frame   (next_frame),
    .complete     (complete)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_FILL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!i_enable)     state_d = ST_FILL;
    else if (complete) state_d = ST_STREAM;
  end

  // o_next gating keeps pulses at least one idle cycle apart.
  assign send = o_pending & i_core_ready & ~o_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold         <= '0;
      o_data       <= '0;
      o_next       <= 1'b0;
      o_pending    <= 1'b0;
      o_drop_count <= '0;
    end else begin
      o_next <= send;
      if (send) o_data <= hold;
      if (complete) begin
        // On a collision send takes the old hold, so nothing is lost.
        hold      <= next_frame;
        o_pending <= 1'b1;
        if (o_pending && !send && o_drop_count != 8'hFF)
          o_drop_count <= o_drop_count + 1'b1;
      end else if (send) begin
        o_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frame_sender.sv
module tb_frame_sender;
  import glove_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_sample_valid = 1'b0;
  sample_t    i_sample = '0;
  logic       i_core_ready = 1'b0;
  logic       o_next;
  frame_t     o_data;
  logic       o_pending;
  logic [7:0] o_drop_count;

  frame_sender dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_sample_valid(i_sample_valid), .i_sample(i_sample),
    .i_core_ready(i_core_ready), .o_next(o_next), .o_data(o_data),
    .o_pending(o_pending), .o_drop_count(o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { frame_t f; int e; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0, pulses = 0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: keeps the last FRAME_LEN accepted samples and the count
  // accepted since enable; a frame is due at count 40, 40+HOP, 40+2*HOP, ...
  sample_t m_win[$];
  int      m_n = 0, m_drop = 0, edge_no = 0;
  bit      m_pend = 0, m_next = 0;
  frame_t  m_hold;

  initial begin
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) begin
        m_win.delete(); exp_q.delete();
        m_n = 0; m_drop = 0; m_pend = 0; m_next = 0; m_hold = '0;
      end else begin
        bit snd, comp;
        edge_no++;
        snd = m_pend && i_core_ready && !m_next;
        if (snd) exp_q.push_back('{m_hold, edge_no});
        m_next = snd;
        comp = 0;
        if (!i_enable) m_n = 0;
        else if (i_sample_valid) begin
          m_win.push_back(i_sample);
          if (m_win.size() > FRAME_LEN) void'(m_win.pop_front());
          m_n++;
          comp = (m_n >= FRAME_LEN) && ((m_n - FRAME_LEN) % HOP == 0);
        end
        if (comp) begin
          if (m_pend && !snd && m_drop < 255) m_drop++;
          for (int i = 0; i < FRAME_LEN; i++) m_hold[i] = m_win[i];
          m_pend = 1;
        end else if (snd) m_pend = 0;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT issues a pulse.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_next) begin
          pulses++;
          if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
          else begin
            exp_t x;
            int bad_i;
            x = exp_q.pop_front();
            chk("pulse_edge", edge_no, x.e);
            bad_i = -1;
            for (int i = 0; i < FRAME_LEN; i++)
              if (o_data[i] !== x.f[i] && bad_i < 0) bad_i = i;
            n_cmp++;
            if (bad_i >= 0) begin
              n_bad++;
              $display("FAIL frame_data[%0d]: got %0d want %0d", bad_i,
                       o_data[bad_i], x.f[bad_i]);
            end
          end
        end else if (exp_q.size() != 0 && exp_q[0].e <= edge_no) begin
          chk("missed_pulse_at_edge", edge_no, -1);
          void'(exp_q.pop_front());
        end
        chk("pending", o_pending, m_pend);
        chk("drop_count", o_drop_count, m_drop);
      end
    end
  end

  task automatic drive(logic en, logic v, sample_t s, logic rdy);
    @(negedge i_clk); #1;
    i_enable = en; i_sample_valid = v; i_sample = s; i_core_ready = rdy;
  endtask

  task automatic idle(int n, logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge i_clk); #1;
    i_rst_n = 0; i_enable = 0; i_sample_valid = 0; i_sample = '0; i_core_ready = 0;
    #2;
    chk("rst_next", o_next, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_drop", o_drop_count, 0);
    chk("rst_data_zero", (o_data == '0), 1);
    repeat (2) @(negedge i_clk);
    #1 i_rst_n = 1;
    pulses = 0;
  endtask

  initial begin
    int exp_frames;
    #1;
    // Test 1: basic frame
    do_reset();
    for (int i = 0; i < 40; i++) drive(1, 1, sample_t'(i), 1);
    idle(6, 1);
    chk("t1_pulses", pulses, 1);
    chk("t1_data0", o_data[0], 0);
    chk("t1_data39", o_data[39], 39);
    chk("t1_drop", o_drop_count, 0);

    // Test 2: frame rate over 120 contiguous samples
    do_reset();
    for (int i = 0; i < 120; i++) drive(1, 1, sample_t'(i), 1);
    idle(6, 1);
    exp_frames = 1 + (120 - 40) / HOP;
    chk("t2_pulses", pulses, exp_frames);
    chk("t2_last_data0", o_data[0], 120 - 40);
    chk("t2_last_data39", o_data[39], 119);

    // Test 3: overwrite while not ready
    do_reset();
    for (int i = 0; i < 80; i++) drive(1, 1, sample_t'(i), 0);
    idle(6, 1);
    chk("t3_pulses", pulses, 1);
    chk("t3_data0", o_data[0], 40);
    chk("t3_drop", o_drop_count, (80 - 40) / HOP);

    // Test 4: ready raised on the edge the next frame completes
    do_reset();
    for (int i = 0; i < 40 + HOP - 1; i++) drive(1, 1, sample_t'(i + 1000), 0);
    drive(1, 1, sample_t'(1000 + 40 + HOP - 1), 1);
    drive(1, 0, '0, 1); #2;
    chk("t4_pending_after_collision", o_pending, 1);
    idle(6, 1);
    chk("t4_pulses", pulses, 2);
    chk("t4_drop", o_drop_count, 0);
    chk("t4_last_data0", o_data[0], 1000 + HOP);

    // Test 5: enable drop after 25 samples, then 40 fresh samples
    do_reset();
    for (int i = 0; i < 25; i++) drive(1, 1, sample_t'(i + 500), 1);
    drive(0, 1, sample_t'(777), 1);
    drive(0, 0, '0, 1);
    for (int i = 0; i < 40; i++) drive(1, 1, sample_t'(i + 2000), 1);
    idle(6, 1);
    chk("t5_pulses", pulses, 1);
    chk("t5_data0", o_data[0], 2000);
    // Reset with a frame pending: no pulse afterwards
    for (int i = 0; i < 40; i++) drive(1, 1, sample_t'(i), 0);
    drive(1, 0, '0, 0); #2;
    chk("t5_pending_before_reset", o_pending, 1);
    do_reset();
    idle(10, 1);
    chk("t5_no_pulse_after_reset", pulses, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 16) != 0, ($urandom % 4) != 0, sample_t'($urandom),
            ($urandom % 3) == 0);
    idle(10, 1);

    // Test 6: drop counter saturation
    do_reset();
    for (int i = 0; i < 40 + 300 * HOP; i++) drive(1, 1, sample_t'(i), 0);
    idle(2, 0);
    chk("t6_drop_sat", o_drop_count, 255);
    idle(6, 1);
    chk("t6_pulses", pulses, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
